// File: rtl/ex_mem_stage_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage_fifo
// Purpose  : Elastic EX/MEM stage buffer with freeze, flush, occupancy and
//            forwarding lookup across all resident entries.
// Revision : 1.0
// ============================================================================
module ex_mem_stage_fifo #(
    parameter  int DATA_W = 16,
    parameter  int REG_W  = 4,
    parameter  int DEPTH  = 2,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              hazard_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [REG_W-1:0]  in_rd_i,
    input  logic [DATA_W-1:0] in_regout_i,
    input  logic [DATA_W-1:0] in_alu_i,
    input  logic [DATA_W-1:0] in_r0_i,
    input  logic              in_wb_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [REG_W-1:0]  out_rd_o,
    output logic [DATA_W-1:0] out_regout_o,
    output logic [DATA_W-1:0] out_alu_o,
    output logic [DATA_W-1:0] out_r0_o,
    output logic              out_wb_o,
    output logic [CNT_W-1:0]  count_o,
    input  logic [REG_W-1:0]  fwd_src_i,
    output logic              fwd_hit_o,
    output logic [DATA_W-1:0] fwd_data_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  wp_q, wp_d;
    logic [PTR_W-1:0]  rp_q, rp_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [REG_W-1:0]  rd_q     [DEPTH];
    logic [DATA_W-1:0] regout_q [DEPTH];
    logic [DATA_W-1:0] alu_q    [DEPTH];
    logic [DATA_W-1:0] r0_q     [DEPTH];
    logic              wb_q     [DEPTH];

    logic w_push;
    logic w_pop;

    // No pass-through when full: a pop in the same cycle does not free a slot.
    assign in_ready_o  = !hazard_i && !flush_i && (count_q < CNT_W'(DEPTH));
    assign out_valid_o = !hazard_i && (count_q != '0);
    assign w_push      = in_valid_i && in_ready_o;
    assign w_pop       = out_valid_o && out_ready_i;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (flush_i) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (w_push) wp_d = wp_q + PTR_W'(1);
            if (w_pop)  rp_d = rp_q + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // Storage is cleared only by reset; flush just rewinds the pointers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]     <= '0;
                regout_q[i] <= '0;
                alu_q[i]    <= '0;
                r0_q[i]     <= '0;
                wb_q[i]     <= 1'b0;
            end
        end else if (w_push) begin
            rd_q[wp_q]     <= in_rd_i;
            regout_q[wp_q] <= in_regout_i;
            alu_q[wp_q]    <= in_alu_i;
            r0_q[wp_q]     <= in_r0_i;
            wb_q[wp_q]     <= in_wb_i;
        end
    end

    assign out_rd_o     = rd_q[rp_q];
    assign out_regout_o = regout_q[rp_q];
    assign out_alu_o    = alu_q[rp_q];
    assign out_r0_o     = r0_q[rp_q];
    assign out_wb_o     = wb_q[rp_q];
    assign count_o      = count_q;

    // Walk from oldest to youngest so the last match seen is the youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx        = '0;
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rp_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && wb_q[idx] && (rd_q[idx] == fwd_src_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = alu_q[idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_stage_fifo
// Purpose  : Scenario tasks plus randomized run against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_ex_mem_stage_fifo;

    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct {
        logic [3:0]  rd;
        logic [15:0] regout;
        logic [15:0] alu;
        logic [15:0] r0;
        logic        wb;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n, hazard, flush, in_valid, in_wb, out_ready;
    logic [3:0]  in_rd, fwd_src;
    logic [15:0] in_regout, in_alu, in_r0;
    logic        in_ready, out_valid, out_wb, fwd_hit;
    logic [3:0]  out_rd;
    logic [15:0] out_regout, out_alu, out_r0, fwd_data;
    logic [CNT_W-1:0] count;

    int   n_checks = 0;
    int   n_fail   = 0;
    ent_t q[$];

    ex_mem_stage_fifo #(.DATA_W(16), .REG_W(4), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n), .hazard_i(hazard), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_rd_i(in_rd),
        .in_regout_i(in_regout), .in_alu_i(in_alu), .in_r0_i(in_r0), .in_wb_i(in_wb),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_rd_o(out_rd),
        .out_regout_o(out_regout), .out_alu_o(out_alu), .out_r0_o(out_r0),
        .out_wb_o(out_wb), .count_o(count), .fwd_src_i(fwd_src),
        .fwd_hit_o(fwd_hit), .fwd_data_o(fwd_data)
    );

    always #5 clk = ~clk;

    function automatic bit m_in_ready();
        return !hazard && !flush && (q.size() < DEPTH);
    endfunction

    function automatic bit m_out_valid();
        return !hazard && (q.size() != 0);
    endfunction

    function automatic bit m_fwd_hit();
        foreach (q[i]) if (q[i].wb && q[i].rd == fwd_src) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] m_fwd_data();
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].wb && q[i].rd == fwd_src) return q[i].alu;
        return 16'h0000;
    endfunction

    task automatic set_in(input bit v, input logic [3:0] rd, input logic [15:0] ro,
                          input logic [15:0] alu, input logic [15:0] r0, input bit wb);
        in_valid = v; in_rd = rd; in_regout = ro; in_alu = alu; in_r0 = r0; in_wb = wb;
    endtask

    // One clock: apply the transfer rules to the model, then settle past the edge.
    task automatic tick();
        bit   pu, po;
        ent_t e;
        pu = in_valid && m_in_ready();
        po = m_out_valid() && out_ready;
        e  = '{rd: in_rd, regout: in_regout, alu: in_alu, r0: in_r0, wb: in_wb};
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (po) void'(q.pop_front());
            if (pu) q.push_back(e);
        end
        #1;
    endtask

    task automatic idle_inputs();
        hazard = 0; flush = 0; out_ready = 0; fwd_src = 4'd0;
        set_in(0, 4'd0, 16'h0, 16'h0, 16'h0, 0);
    endtask

    task automatic do_flush();
        flush = 1; tick(); flush = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        set_in(1, 4'd1, 16'hAAAA, 16'h1234, 16'h5555, 1); tick();
        set_in(1, 4'd2, 16'hBBBB, 16'h5678, 16'h6666, 1); tick();
        set_in(0, 4'd0, 16'h0, 16'h0, 16'h0, 0);
        n_checks++; if (count !== 2) begin n_fail++; $display("FAIL reset_pre_count got=%0d exp=2", count); end
        #2 rst_n = 0; q.delete();
        #1;
        n_checks++; if (count !== 0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (out_rd !== 4'd0) begin n_fail++; $display("FAIL reset_out_rd got=%0d exp=0", out_rd); end
        n_checks++; if (out_alu !== 16'h0) begin n_fail++; $display("FAIL reset_out_alu got=%h exp=0000", out_alu); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        fwd_src = 4'd1; #1;
        n_checks++; if (fwd_hit !== 1'b0 || fwd_data !== 16'h0) begin n_fail++; $display("FAIL reset_fwd got=%b/%h exp=0/0000", fwd_hit, fwd_data); end
        @(posedge clk); #1 rst_n = 1;
    endtask

    task automatic test_stream();
        idle_inputs(); out_ready = 1;
        set_in(1, 4'd3, 16'h0002, 16'h0003, 16'h0006, 1); tick();
        n_checks++;
        if (out_valid !== 1 || out_rd !== 4'd3 || out_regout !== 16'h0002 || out_alu !== 16'h0003 ||
            out_r0 !== 16'h0006 || out_wb !== 1) begin
            n_fail++; $display("FAIL stream_first got v=%b rd=%0d ro=%h alu=%h r0=%h wb=%b exp 1/3/0002/0003/0006/1",
                               out_valid, out_rd, out_regout, out_alu, out_r0, out_wb);
        end
        for (int i = 0; i < 8; i++) begin
            set_in(1, 4'(i + 8), 16'(i), 16'h1000 + 16'(i), 16'h2000 + 16'(i), i[0]); tick();
            n_checks++;
            if (count !== 1 || out_valid !== 1 || out_alu !== 16'h1000 + 16'(i) || out_rd !== 4'(i + 8)) begin
                n_fail++; $display("FAIL stream_b2b[%0d] got cnt=%0d v=%b alu=%h rd=%0d exp 1/1/%h/%0d",
                                   i, count, out_valid, out_alu, out_rd, 16'h1000 + 16'(i), i + 8);
            end
        end
        set_in(0, 4'd0, 16'h0, 16'h0, 16'h0, 0); tick();
        n_checks++; if (count !== 0) begin n_fail++; $display("FAIL stream_drain got=%0d exp=0", count); end
    endtask

    task automatic test_full();
        idle_inputs();
        set_in(1, 4'd1, 16'h0, 16'hA0A0, 16'h0, 1); tick();
        set_in(1, 4'd2, 16'h0, 16'hB0B0, 16'h0, 1); tick();
        set_in(1, 4'd3, 16'h0, 16'hC0C0, 16'h0, 1);
        #1;
        n_checks++; if (count !== 2 || in_ready !== 0) begin n_fail++; $display("FAIL full_state got cnt=%0d rdy=%b exp 2/0", count, in_ready); end
        tick();
        n_checks++; if (count !== 2 || out_alu !== 16'hA0A0) begin n_fail++; $display("FAIL full_hold got cnt=%0d alu=%h exp 2/A0A0", count, out_alu); end
        out_ready = 1; #1;
        n_checks++; if (in_ready !== 0) begin n_fail++; $display("FAIL full_no_passthru got=%b exp=0", in_ready); end
        tick();
        n_checks++; if (count !== 1 || out_alu !== 16'hB0B0) begin n_fail++; $display("FAIL full_popA got cnt=%0d alu=%h exp 1/B0B0", count, out_alu); end
        tick();
        n_checks++; if (count !== 1 || out_alu !== 16'hC0C0) begin n_fail++; $display("FAIL full_popB got cnt=%0d alu=%h exp 1/C0C0", count, out_alu); end
        set_in(0, 4'd0, 16'h0, 16'h0, 16'h0, 0); tick();
        n_checks++; if (count !== 0 || out_valid !== 0) begin n_fail++; $display("FAIL full_popC got cnt=%0d v=%b exp 0/0", count, out_valid); end
    endtask

    task automatic test_hazard();
        idle_inputs();
        set_in(1, 4'd6, 16'h0, 16'hD00D, 16'h0, 1); tick();
        hazard = 1; out_ready = 1;
        set_in(1, 4'd7, 16'h0, 16'hEEEE, 16'h0, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (in_ready !== 0 || out_valid !== 0 || count !== 1 || out_alu !== 16'hD00D) begin
                n_fail++; $display("FAIL hazard_hold[%0d] got rdy=%b v=%b cnt=%0d alu=%h exp 0/0/1/D00D",
                                   i, in_ready, out_valid, count, out_alu);
            end
            tick();
        end
        hazard = 0; set_in(0, 4'd0, 16'h0, 16'h0, 16'h0, 0); #1;
        n_checks++; if (out_valid !== 1 || out_alu !== 16'hD00D) begin n_fail++; $display("FAIL hazard_release got v=%b alu=%h exp 1/D00D", out_valid, out_alu); end
        tick();
        n_checks++; if (count !== 0) begin n_fail++; $display("FAIL hazard_drain got=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        idle_inputs(); fwd_src = 4'd9;
        set_in(1, 4'd9, 16'h0, 16'h9999, 16'h0, 1); tick();
        set_in(1, 4'd9, 16'h0, 16'h8888, 16'h0, 1); tick();
        flush = 1; hazard = 1; set_in(1, 4'd9, 16'h0, 16'h7777, 16'h0, 1); #1;
        n_checks++; if (in_ready !== 0 || count !== 2) begin n_fail++; $display("FAIL flush_pre got rdy=%b cnt=%0d exp 0/2", in_ready, count); end
        tick();
        flush = 0; hazard = 0; set_in(0, 4'd0, 16'h0, 16'h0, 16'h0, 0); #1;
        n_checks++;
        if (count !== 0 || out_valid !== 0 || fwd_hit !== 0) begin
            n_fail++; $display("FAIL flush_after got cnt=%0d v=%b hit=%b exp 0/0/0", count, out_valid, fwd_hit);
        end
        set_in(1, 4'd4, 16'h0, 16'h4444, 16'h0, 1); tick();
        set_in(0, 4'd0, 16'h0, 16'h0, 16'h0, 0); out_ready = 1; #1;
        n_checks++; if (out_valid !== 1 || out_alu !== 16'h4444 || count !== 1) begin n_fail++; $display("FAIL flush_repush got v=%b alu=%h cnt=%0d exp 1/4444/1", out_valid, out_alu, count); end
        tick();
    endtask

    task automatic test_forward();
        idle_inputs();
        set_in(1, 4'd5, 16'h0, 16'h1111, 16'h0, 1); tick();
        set_in(1, 4'd5, 16'h0, 16'h2222, 16'h0, 1); tick();
        set_in(0, 4'd0, 16'h0, 16'h0, 16'h0, 0); fwd_src = 4'd5; #1;
        n_checks++; if (fwd_hit !== 1 || fwd_data !== 16'h2222) begin n_fail++; $display("FAIL fwd_youngest got %b/%h exp 1/2222", fwd_hit, fwd_data); end
        hazard = 1; #1;
        n_checks++; if (fwd_hit !== 1 || fwd_data !== 16'h2222) begin n_fail++; $display("FAIL fwd_hazard got %b/%h exp 1/2222", fwd_hit, fwd_data); end
        hazard = 0; do_flush();
        set_in(1, 4'd5, 16'h0, 16'h1111, 16'h0, 1); tick();
        set_in(1, 4'd5, 16'h0, 16'h2222, 16'h0, 0); tick();
        set_in(0, 4'd0, 16'h0, 16'h0, 16'h0, 0); #1;
        n_checks++; if (fwd_hit !== 1 || fwd_data !== 16'h1111) begin n_fail++; $display("FAIL fwd_skip_nowb got %b/%h exp 1/1111", fwd_hit, fwd_data); end
        fwd_src = 4'd7; #1;
        n_checks++; if (fwd_hit !== 0 || fwd_data !== 16'h0) begin n_fail++; $display("FAIL fwd_miss got %b/%h exp 0/0000", fwd_hit, fwd_data); end
        do_flush();
    endtask

    task automatic test_random();
        ent_t h;
        idle_inputs(); do_flush();
        for (int c = 0; c < 600; c++) begin
            hazard    = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 24) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            fwd_src   = 4'($urandom_range(0, 3));
            set_in($urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)), 16'($urandom),
                   16'($urandom), 16'($urandom), $urandom_range(0, 1) == 1);
            #1;
            n_checks++;
            if (in_ready !== m_in_ready() || out_valid !== m_out_valid() || count !== CNT_W'(q.size())) begin
                n_fail++; $display("FAIL rand_ctrl[%0d] got rdy=%b v=%b cnt=%0d exp %b/%b/%0d",
                                   c, in_ready, out_valid, count, m_in_ready(), m_out_valid(), q.size());
            end
            n_checks++;
            if (fwd_hit !== m_fwd_hit() || fwd_data !== m_fwd_data()) begin
                n_fail++; $display("FAIL rand_fwd[%0d] got %b/%h exp %b/%h", c, fwd_hit, fwd_data, m_fwd_hit(), m_fwd_data());
            end
            if (q.size() != 0) begin
                h = q[0];
                n_checks++;
                if (out_rd !== h.rd || out_regout !== h.regout || out_alu !== h.alu || out_r0 !== h.r0 || out_wb !== h.wb) begin
                    n_fail++; $display("FAIL rand_head[%0d] got %0d/%h/%h/%h/%b exp %0d/%h/%h/%h/%b", c,
                                       out_rd, out_regout, out_alu, out_r0, out_wb, h.rd, h.regout, h.alu, h.r0, h.wb);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        test_reset();
        test_stream();
        test_full();
        test_hazard();
        test_flush();
        test_forward();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
